// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for div/divu: one result per 33 cycles,
// quotient on the lo path and remainder on the hi path.
module ex_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stallreq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned SR_W  = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ZERO   = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               quo_neg_q, quo_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dz_q, dz_d;
    logic               stall_c;

    logic [SR_W-1:0]    sr_shift;
    logic [SR_W-1:0]    sr_step;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   step_quo;
    logic [WIDTH-1:0]   step_rem;

    // Operand magnitudes; the most negative value maps onto itself as unsigned.
    always_comb begin
        a_abs = (signed_div && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
        b_abs = (signed_div && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;
    end

    // One restoring step on {rem, quo}.
    always_comb begin
        sr_shift = sr_q << 1;
        sr_step  = sr_shift;
        if (sr_shift[SR_W-1:WIDTH] >= {1'b0, div_q}) begin
            sr_step[SR_W-1:WIDTH] = sr_shift[SR_W-1:WIDTH] - {1'b0, div_q};
            sr_step[0]            = 1'b1;
        end
        step_quo = sr_step[WIDTH-1:0];
        step_rem = sr_step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        div_d     = div_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        stall_c   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    stall_c = 1'b1;
                    if (divisor == '0) begin
                        state_d = S_ZERO;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        sr_d      = {{(WIDTH + 1){1'b0}}, a_abs};
                        div_d     = b_abs;
                        quo_neg_d = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rem_neg_d = signed_div & dividend[WIDTH-1];
                        cnt_d     = '0;
                    end
                end
            end
            S_ZERO: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                stall_c = 1'b1;
                sr_d    = sr_step;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FINISH;
                    quo_d   = quo_neg_q ? (WIDTH'(0) - step_quo) : step_quo;
                    rem_d   = rem_neg_q ? (WIDTH'(0) - step_rem) : step_rem;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush annuls the operation and any completion it would have produced.
        if (flush) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            quo_d   = quo_q;
            rem_d   = rem_q;
            dz_d    = dz_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            div_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            div_q     <= div_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
        end
    end

    // The accept term is combinational so the stall lands in the request cycle.
    assign stallreq  = rst & stall_c;
    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed checks for ex_div_unit: latency, stall window, signed/unsigned
// results, divide-by-zero, flush and asynchronous reset.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        stallreq;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int n_chk  = 0;
    int n_pass = 0;

    ex_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .stallreq   (stallreq),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Issue one request at posedge+1 and follow it to completion.
    // glitch > 0 raises start (with a zero divisor) during that cycle of RUN.
    task automatic do_div(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] qe, input logic [31:0] re,
                          input logic dze, input int lat_e, input int glitch);
        int lat;
        int stall_cnt;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        #1;
        stall_cnt = stallreq ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            if (stallreq) stall_cnt++;
            if (lat == glitch) begin
                start    = 1'b1;
                dividend = 32'd100;
                divisor  = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(lat_e));
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(lat_e));
        chk({tag, "_stall_done"}, 32'(stallreq), 32'd0);
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        chk({tag, "_quotient"}, quotient, qe);
        chk({tag, "_remainder"}, remainder, re);
        chk({tag, "_div_zero"}, 32'(div_zero), 32'(dze));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dn;
        // Reset values
        #12;
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0);
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 0);
        do_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
        do_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0);
        do_div("div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1, 0);

        // Flush in RUN cycle 10: no done, results from the zero-divide retained
        signed_div = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_stallreq", 32'(stallreq), 32'd0);
        dn = 0;
        repeat (40) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        chk("flush_no_done", 32'(dn), 32'd0);
        chk("flush_quotient", quotient, 32'hFFFF_FFFF);
        chk("flush_remainder", remainder, 32'h1234_5678);
        chk("flush_div_zero", 32'(div_zero), 32'd1);
        do_div("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33, 0);

        // Asynchronous reset between edges mid-RUN
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_stallreq", 32'(stallreq), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_quotient", quotient, 32'd0);
        chk("arst_remainder", remainder, 32'd0);
        chk("arst_div_zero", 32'(div_zero), 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        do_div("u9_4_glitch", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 33, 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative 32-bit radix-2 divider used by the execute stage for `div`/`divu`. Accepts one operand pair, iterates for 32 cycles while holding the pipeline through a stall request, then presents quotient and remainder for one `done` cycle. The execute stage packs these results into the hi/lo write fields of the bus it sends to the memory stage (`lo` is the quotient, `hi` is the remainder).

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported; the parameter exists for bench scaling.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `flush` input 1: annuls any operation in progress, synchronous.
- `start` input 1: request a division. Sampled only in IDLE.
- `signed_div` input 1: 1 selects `div`, 0 selects `divu`. Sampled with `start`.
- `dividend` input WIDTH: operand a, sampled with `start`.
- `divisor` input WIDTH: operand b, sampled with `start`.
- `stallreq` output 1: asks the stall controller to freeze IF/ID/EX.
- `busy` output 1: an operation is in progress (any state other than IDLE).
- `done` output 1: results valid this cycle. One-cycle pulse.
- `quotient` output WIDTH: lo result.
- `remainder` output WIDTH: hi result.
- `div_zero` output 1: the last completed operation had divisor 0.

## Operation
- States:
  - IDLE: waiting for a request.
  - ZERO: handling a zero divisor.
  - RUN: iterating.
  - FINISH: presenting results.
- IDLE, `start`=1, `divisor`=0 → ZERO.
- IDLE, `start`=1, `divisor`≠0 → RUN.
  - Latch `|a|` and `|b|` (magnitudes when `signed_div`, raw values otherwise).
  - Latch `neg_q` = `signed_div` & (a[31]^b[31]) and `neg_r` = `signed_div` & a[31].
  - Clear the 6-bit iteration counter.
- RUN, each cycle: one restoring step on a 65-bit shift register {rem[32:0], quo[31:0]}.
  - Shift left by 1.
  - If the upper part ≥ `|b|`, subtract `|b|` and set quo[0]=1.
  - Increment the counter.
  - After the 32nd step → FINISH.
- FINISH:
  - `quotient` = `neg_q` ? −quo : quo.
  - `remainder` = `neg_r` ? −rem : rem.
  - Both are registered on entry to FINISH.
  - `done`=1, `div_zero`=0, → IDLE.
- ZERO: `quotient`=32'hFFFF_FFFF, `remainder`=`dividend`, `div_zero`=1, `done`=1, → IDLE.
- Arithmetic is modulo 2^32. Signed 0x8000_0000 / 0xFFFF_FFFF gives `quotient`=0x8000_0000 and `remainder`=0, with no trap.
- `quotient`, `remainder` and `div_zero` hold their last values until the next completion. Nothing else updates them.
- `start` outside IDLE is ignored.
- `flush` has priority over everything except `rst`.
  - Any state → IDLE next cycle; no `done`.
  - Result registers are left unchanged.
  - A `flush` in the same cycle as `start` in IDLE discards the request.
- `stallreq` = (state==IDLE & `start` & ~`flush`) | state==RUN | state==ZERO-entry-pending.
  - Implement as: combinational high on an accepted start, and registered high throughout RUN.
  - Low in FINISH and ZERO, so the instruction advances in the `done` cycle.
- The execute stage deasserts `start` for an instruction once it has seen `done`.
  - If `start` is still high in the IDLE cycle after `done`, that is a new request and is accepted.
- `rst` asserted (low) at any time: state=IDLE immediately, counter=0, all outputs 0. This includes mid-RUN.

## Timing
- Reset values: `stallreq`=0, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0.
- Nonzero divisor:
  - `start` accepted at edge 0.
  - RUN occupies cycles 1–32.
  - `done`=1 in cycle 33.
  - Latency is 33 cycles from the accepting edge to the `done` cycle.
  - `busy` is 1 in cycles 1–33.
  - `stallreq` is 1 in cycles 0–32 and 0 in cycle 33.
- Zero divisor: `done`=1 in cycle 1. `stallreq` is 1 in cycle 0 only.
- Back-to-back: a new `start` is accepted at the earliest in the cycle after `done`.
- `done` is never asserted for two consecutive cycles.

## Test plan
- Unsigned 100 / 7 (`signed_div`=0) → `done` in cycle 33, `quotient`=14, `remainder`=2, `div_zero`=0; `stallreq` high for exactly 33 cycles.
- Signed −7 / 2 (0xFFFF_FFF9 / 2) → `quotient`=0xFFFF_FFFD (−3), `remainder`=0xFFFF_FFFF (−1). Signed 7 / −2 → `quotient`=−3, `remainder`=1.
- Corner cases:
  - Signed 0x8000_0000 / 0xFFFF_FFFF → `quotient`=0x8000_0000, `remainder`=0.
  - Unsigned 0xFFFF_FFFF / 1 → `quotient`=0xFFFF_FFFF, `remainder`=0.
- Divisor 0 with `dividend`=0x1234_5678 → `done` in cycle 1, `quotient`=0xFFFF_FFFF, `remainder`=0x1234_5678, `div_zero`=1.
- `flush` in cycle 10 of RUN:
  - Next cycle `busy`=0, `stallreq`=0.
  - No `done` ever appears.
  - Outputs retain the previous results.
  - A subsequent 50/5 → `quotient`=10, `remainder`=0 after 33 cycles.
- `rst` pulled low asynchronously mid-RUN (between edges) → all outputs 0 before the next edge. After release, `start` 9/4 → `quotient`=2, `remainder`=1. A `start` pulse during RUN → ignored, and the current result is unaffected.
